// File: rtl/flappy_pipe_field_if.sv
// Bundle between the game controller/raster side and the pipe-field engine.
// master: controller and raster timing. slave: the pipe field.
interface flappy_pipe_field_if;
    logic       frame_tick;
    logic       run;
    logic       restart;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       video_active;
    logic [8:0] bird_y;
    logic       pipe_pix;
    logic       gap_pix;
    logic       bird_pix;
    logic       collide;
    logic [7:0] score;
    logic       score_pulse;

    modport master (
        output frame_tick, run, restart, pix_x, pix_y, video_active, bird_y,
        input  pipe_pix, gap_pix, bird_pix, collide, score, score_pulse
    );

    modport slave (
        input  frame_tick, run, restart, pix_x, pix_y, video_active, bird_y,
        output pipe_pix, gap_pix, bird_pix, collide, score, score_pulse
    );
endinterface

// File: rtl/flappy_pipe_field.sv
// Multi-channel scrolling pipe field: per-frame scroll/respawn, scoring,
// sticky collision and a 2-stage pixel classifier feeding the colour mux.
module flappy_pipe_field #(
    parameter int         NUM_PIPES    = 3,
    parameter int         PIPE_W       = 40,
    parameter int         GAP_H        = 100,
    parameter int         PIPE_SPACING = 240,
    parameter int         SCREEN_W     = 640,
    parameter int         SCREEN_H     = 480,
    parameter int         SPEED        = 2,
    parameter int         HOLE_MIN     = 40,
    parameter int         BIRD_X       = 100,
    parameter int         BIRD_SIZE    = 8,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input logic           clk,
    input logic           rst_n,
    flappy_pipe_field_if.slave bus
);

    // All geometry compares are done in 12 bits so x+PIPE_W never wraps.
    localparam logic [11:0] C_SCREEN_W = 12'(SCREEN_W);
    localparam logic [11:0] C_SCREEN_H = 12'(SCREEN_H);
    localparam logic [11:0] C_PIPE_W   = 12'(PIPE_W);
    localparam logic [11:0] C_GAP_H    = 12'(GAP_H);
    localparam logic [11:0] C_SPEED    = 12'(SPEED);
    localparam logic [11:0] C_WRAP     = 12'(NUM_PIPES*PIPE_SPACING - SPEED);
    localparam logic [11:0] C_BIRD_X   = 12'(BIRD_X);
    localparam logic [11:0] C_BIRD_SZ  = 12'(BIRD_SIZE);
    localparam logic [8:0]  C_HOLE_MIN = 9'(HOLE_MIN);
    localparam logic [8:0]  C_HOLE_INI = 9'((SCREEN_H - GAP_H) / 2);
    localparam logic [7:0]  C_SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic [10:0]          x_pos    [NUM_PIPES];
    logic [8:0]           hole_row [NUM_PIPES];
    logic [10:0]          x_adv    [NUM_PIPES];
    logic [8:0]           hole_adv [NUM_PIPES];
    logic [NUM_PIPES-1:0] scored;
    logic [2:0]           score_cnt;
    logic [8:0]           score_sum;
    logic [7:0]           score_sat;
    logic [7:0]           score_q;
    logic                 score_pulse_q;
    logic                 collide_q;
    logic [7:0]           lfsr;
    logic [7:0]           lfsr_next;
    logic                 floor_hit;

    logic [NUM_PIPES-1:0] in_x, in_gap, in_x_d, in_gap_d;
    logic [9:0]           px_d, py_d;
    logic                 va_d;
    logic                 bird_hit;
    logic                 pipe_q, gap_q, bird_q;

    // Next field on a running tick: scroll or respawn each channel, count passes.
    always_comb begin
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        score_cnt = 3'd0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if ({1'b0, x_pos[i]} < C_SPEED) begin
                x_adv[i]    = 11'({1'b0, x_pos[i]} + C_WRAP);
                hole_adv[i] = C_HOLE_MIN + {1'b0, lfsr};
            end else begin
                x_adv[i]    = 11'({1'b0, x_pos[i]} - C_SPEED);
                hole_adv[i] = hole_row[i];
            end
            scored[i] = (({1'b0, x_pos[i]} + C_PIPE_W) >= C_BIRD_X) &&
                        (({1'b0, x_adv[i]} + C_PIPE_W) <  C_BIRD_X);
            score_cnt = score_cnt + {2'b00, scored[i]};
        end
        score_sum = {1'b0, score_q} + {6'd0, score_cnt};
        score_sat = score_sum[8] ? 8'hFF : score_sum[7:0];
        floor_hit = ({3'b000, bus.bird_y} + C_BIRD_SZ) > C_SCREEN_H;
    end

    // Field, score, LFSR and sticky collision; restart overrides any tick work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_pos[i]    <= 11'(SCREEN_W + i*PIPE_SPACING);
                hole_row[i] <= C_HOLE_INI;
            end
            lfsr          <= C_SEED;
            score_q       <= 8'd0;
            score_pulse_q <= 1'b0;
            collide_q     <= 1'b0;
        end else begin
            score_pulse_q <= 1'b0;
            if (bus.frame_tick) lfsr <= lfsr_next;
            if (bus.restart) begin
                for (int i = 0; i < NUM_PIPES; i++) begin
                    x_pos[i]    <= 11'(SCREEN_W + i*PIPE_SPACING);
                    hole_row[i] <= C_HOLE_INI;
                end
                score_q   <= 8'd0;
                collide_q <= 1'b0;
            end else begin
                if (bus.frame_tick && bus.run) begin
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        x_pos[i]    <= x_adv[i];
                        hole_row[i] <= hole_adv[i];
                    end
                    score_q       <= score_sat;
                    score_pulse_q <= (score_cnt != 3'd0) && (score_q != 8'hFF);
                    if (floor_hit) collide_q <= 1'b1;
                end
                if (pipe_q && bird_q) collide_q <= 1'b1;
            end
        end
    end

    // Per-channel column and hole compares against the incoming pixel.
    always_comb begin
        for (int i = 0; i < NUM_PIPES; i++) begin
            in_x[i]   = ({1'b0, x_pos[i]} < C_SCREEN_W) &&
                        ({2'b00, bus.pix_x} >= {1'b0, x_pos[i]}) &&
                        ({2'b00, bus.pix_x} <  ({1'b0, x_pos[i]} + C_PIPE_W));
            in_gap[i] = ({2'b00, bus.pix_y} >= {3'b000, hole_row[i]}) &&
                        ({2'b00, bus.pix_y} <  ({3'b000, hole_row[i]} + C_GAP_H));
        end
        bird_hit = ({2'b00, px_d} >= C_BIRD_X) &&
                   ({2'b00, px_d} <  (C_BIRD_X + C_BIRD_SZ)) &&
                   ({2'b00, py_d} >= {3'b000, bus.bird_y}) &&
                   ({2'b00, py_d} <  ({3'b000, bus.bird_y} + C_BIRD_SZ));
    end

    // Two-stage render pipeline: stage 1 holds compares, stage 2 the pixel classes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_d     <= 10'd0;
            py_d     <= 10'd0;
            va_d     <= 1'b0;
            in_x_d   <= '0;
            in_gap_d <= '0;
            pipe_q   <= 1'b0;
            gap_q    <= 1'b0;
            bird_q   <= 1'b0;
        end else begin
            px_d     <= bus.pix_x;
            py_d     <= bus.pix_y;
            va_d     <= bus.video_active;
            in_x_d   <= in_x;
            in_gap_d <= in_gap;
            pipe_q   <= va_d && |(in_x_d & ~in_gap_d);
            gap_q    <= va_d && |(in_x_d & in_gap_d);
            bird_q   <= va_d && bird_hit;
        end
    end

    assign bus.pipe_pix    = pipe_q;
    assign bus.gap_pix     = gap_q;
    assign bus.bird_pix    = bird_q;
    assign bus.collide     = collide_q;
    assign bus.score       = score_q;
    assign bus.score_pulse = score_pulse_q;

endmodule

// File: tb/tb_flappy_pipe_field.sv
// Bench for flappy_pipe_field: directed test-plan steps plus a randomized
// stretch, all compared against a behavioural model of the pipe field.
module tb_flappy_pipe_field;
    localparam int NP = 3, PW = 40, GH = 100, SP = 240, SW = 640, SH = 480;
    localparam int SPD = 2, HMIN = 40, BX = 100, BS = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    flappy_pipe_field_if bus ();

    flappy_pipe_field dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int m_x [NP];
    int m_hole [NP];
    int m_lfsr, m_score, m_pulse, m_collide;
    int ncmp = 0;
    int nfail = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp)
        else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_step(input int l);
        int fb;
        fb = $countones(l & 'hB8) & 1;
        return ((l << 1) | fb) & 255;
    endfunction

    function automatic void m_init_field();
        for (int i = 0; i < NP; i++) begin
            m_x[i]    = SW + i*SP;
            m_hole[i] = (SH - GH) / 2;
        end
        m_score   = 0;
        m_collide = 0;
        m_pulse   = 0;
    endfunction

    task automatic chk_field();
        for (int i = 0; i < NP; i++) begin
            chk("x_pos", 32'(dut.x_pos[i]), 32'(m_x[i]));
            chk("hole_row", 32'(dut.hole_row[i]), 32'(m_hole[i]));
        end
        chk("lfsr", 32'(dut.lfsr), 32'(m_lfsr));
    endtask

    task automatic do_tick(input bit r, input bit rs);
        int lv, cnt;
        bus.run        = r;
        bus.restart    = rs;
        bus.frame_tick = 1'b1;
        lv      = m_lfsr;
        m_lfsr  = lfsr_step(m_lfsr);
        m_pulse = 0;
        if (rs) begin
            m_init_field();
        end else if (r) begin
            cnt = 0;
            for (int i = 0; i < NP; i++) begin
                if (m_x[i] < SPD) begin
                    m_x[i]    = m_x[i] + NP*SP - SPD;
                    m_hole[i] = HMIN + lv;
                end else begin
                    if (m_x[i] + PW >= BX && m_x[i] - SPD + PW < BX) cnt++;
                    m_x[i] = m_x[i] - SPD;
                end
            end
            if (cnt > 0 && m_score < 255) m_pulse = 1;
            m_score = (m_score + cnt > 255) ? 255 : m_score + cnt;
            if (int'(bus.bird_y) + BS > SH) m_collide = 1;
        end
        step();
        bus.frame_tick = 1'b0;
        bus.restart    = 1'b0;
        chk("score", 32'(bus.score), 32'(m_score));
        chk("score_pulse", 32'(bus.score_pulse), 32'(m_pulse));
        chk("collide_tick", 32'(bus.collide), 32'(m_collide));
        step();
        chk("score_pulse_drop", 32'(bus.score_pulse), 32'd0);
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        m_init_field();
        step();
        bus.restart = 1'b0;
        chk("restart_collide", 32'(bus.collide), 32'(m_collide));
        chk("restart_score", 32'(bus.score), 32'(m_score));
    endtask

    // One pixel for one cycle; outputs must be idle, then the class, then idle again.
    task automatic probe(input int px, input int py, input bit va, output logic [2:0] obs);
        bit ix, ig, e_pipe, e_gap, e_bird;
        logic [2:0] e;
        e_pipe = 0;
        e_gap  = 0;
        for (int i = 0; i < NP; i++) begin
            ix = (m_x[i] < SW) && (px >= m_x[i]) && (px < m_x[i] + PW);
            ig = (py >= m_hole[i]) && (py < m_hole[i] + GH);
            if (ix && !ig) e_pipe = 1;
            if (ix && ig)  e_gap  = 1;
        end
        e_bird = (px >= BX) && (px < BX + BS) &&
                 (py >= int'(bus.bird_y)) && (py < int'(bus.bird_y) + BS);
        e = va ? {e_pipe, e_gap, e_bird} : 3'b000;
        bus.pix_x        = 10'(px);
        bus.pix_y        = 10'(py);
        bus.video_active = va;
        step();
        chk("latency1", 32'({bus.pipe_pix, bus.gap_pix, bus.bird_pix}), 32'd0);
        bus.video_active = 1'b0;
        step();
        obs = {bus.pipe_pix, bus.gap_pix, bus.bird_pix};
        chk("pixel_class", 32'(obs), 32'(e));
        if (e[2] && e[0]) m_collide = 1;
        step();
        chk("latency3", 32'({bus.pipe_pix, bus.gap_pix, bus.bird_pix}), 32'd0);
        chk("collide_pix", 32'(bus.collide), 32'(m_collide));
    endtask

    initial begin
        logic [2:0] obs;
        int lv, px, py, k;
        bit r, rs;

        bus.frame_tick   = 1'b0;
        bus.run          = 1'b0;
        bus.restart      = 1'b0;
        bus.pix_x        = 10'd0;
        bus.pix_y        = 10'd0;
        bus.video_active = 1'b0;
        bus.bird_y       = 9'd200;
        rst_n            = 1'b0;
        m_lfsr           = 'hA5;
        m_init_field();
        repeat (3) step();
        chk("rst_outs", 32'({bus.pipe_pix, bus.gap_pix, bus.bird_pix, bus.collide,
                             bus.score_pulse, bus.score}), 32'd0);
        chk_field();
        rst_n = 1'b1;
        step();

        // Reset and scroll
        do_tick(1, 0);
        chk("x0_t1", 32'(dut.x_pos[0]), 32'd638);
        chk("x1_t1", 32'(dut.x_pos[1]), 32'd878);
        chk("x2_t1", 32'(dut.x_pos[2]), 32'd1118);
        probe(70, 50, 1, obs);
        chk("plan_offscreen", 32'(obs), 32'b000);

        // Scoring and render at x0=60
        repeat (289) do_tick(1, 0);
        chk("x0_t290", 32'(dut.x_pos[0]), 32'd60);
        chk("score_t290", 32'(bus.score), 32'd0);
        probe(70, 50, 1, obs);
        chk("plan_pipe_top", 32'(obs), 32'b100);
        probe(70, 200, 1, obs);
        chk("plan_gap", 32'(obs), 32'b010);
        probe(70, 290, 1, obs);
        chk("plan_pipe_bot", 32'(obs), 32'b100);
        probe(70, 50, 0, obs);
        chk("plan_inactive", 32'(obs), 32'b000);
        do_tick(1, 0);
        chk("x0_t291", 32'(dut.x_pos[0]), 32'd58);
        chk("score_t291", 32'(bus.score), 32'd1);

        // Respawn
        repeat (29) do_tick(1, 0);
        chk("x0_t320", 32'(dut.x_pos[0]), 32'd0);
        lv = m_lfsr;
        do_tick(1, 0);
        chk("x0_t321", 32'(dut.x_pos[0]), 32'd718);
        chk("hole0_t321", 32'(dut.hole_row[0]), 32'(HMIN + lv));
        chk_field();

        // Randomized frames and pixels
        repeat (150) begin
            bus.bird_y = 9'($urandom_range(0, 479));
            rs = ($urandom_range(0, 29) == 0);
            r  = ($urandom_range(0, 3) != 0);
            do_tick(r, rs);
            chk_field();
            repeat (2) begin
                k = $urandom_range(0, NP-1);
                case ($urandom_range(0, 2))
                    0: begin
                        px = m_x[k] + $urandom_range(0, PW-1);
                        py = $urandom_range(0, 479);
                    end
                    1: begin
                        px = BX + $urandom_range(0, BS-1);
                        py = int'(bus.bird_y) + $urandom_range(0, BS-1);
                    end
                    default: begin
                        px = $urandom_range(0, 639);
                        py = $urandom_range(0, 479);
                    end
                endcase
                if (px > 1023) px = $urandom_range(0, 639);
                if (py > 1023) py = $urandom_range(0, 479);
                probe(px, py, ($urandom_range(0, 3) != 0), obs);
            end
        end

        // Collision with a pipe, stickiness and restart
        do_restart();
        chk("x0_restart", 32'(dut.x_pos[0]), 32'd640);
        bus.bird_y = 9'd200;
        repeat (280) do_tick(1, 0);
        chk("x0_t280", 32'(dut.x_pos[0]), 32'd80);
        bus.bird_y = 9'd45;
        probe(100, 45, 1, obs);
        chk("plan_bird_on_pipe", 32'(obs), 32'b101);
        chk("collide_set", 32'(bus.collide), 32'd1);
        repeat (3) do_tick(1, 0);
        chk("collide_sticky", 32'(bus.collide), 32'd1);
        do_restart();
        chk("collide_clr", 32'(bus.collide), 32'd0);
        chk("score_clr", 32'(bus.score), 32'd0);
        chk("x0_clr", 32'(dut.x_pos[0]), 32'd640);

        // Freeze: positions hold, LFSR keeps stepping
        repeat (5) do_tick(0, 0);
        chk("x0_frozen", 32'(dut.x_pos[0]), 32'd640);
        chk_field();

        // Floor collision, then restart beating a simultaneous floor hit
        bus.bird_y = 9'd475;
        do_tick(1, 0);
        chk("floor_collide", 32'(bus.collide), 32'd1);
        do_tick(1, 1);
        chk("restart_vs_floor", 32'(bus.collide), 32'd0);
        chk_field();

        // Asynchronous reset mid-cycle
        do_tick(1, 0);
        #2;
        rst_n = 1'b0;
        m_lfsr = 'hA5;
        m_init_field();
        #1;
        chk("async_collide", 32'(bus.collide), 32'd0);
        chk_field();
        step();
        rst_n = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/flappy_pipe_field.md
# flappy_pipe_field

Parametrised pipe-field engine and pixel renderer for the Flappy Bird VGA design. It sits between the game controller and the RGB mux, and replaces the single fixed pipe with `NUM_PIPES` independently scrolling pipe channels. It owns:
- per-frame scrolling, and respawn of each pipe with an LFSR-chosen hole;
- pass-the-bird scoring and sticky bird/pipe/floor collision detection;
- a 2-stage registered pixel classifier that feeds the colour mux.

## Interface
Parameters:
- `NUM_PIPES`, 3, number of pipe channels (1–4)
- `PIPE_W`, 40, pipe width in pixels
- `GAP_H`, 100, hole height in pixels
- `PIPE_SPACING`, 240, left-edge distance between consecutive pipes
- `SCREEN_W` / `SCREEN_H`, 640 / 480, visible area
- `SPEED`, 2, pixels scrolled per frame tick
- `HOLE_MIN`, 40, minimum hole top row
- `BIRD_X` / `BIRD_SIZE`, 100 / 8, bird column and square size
- `LFSR_SEED`, 8'hA5, LFSR reset value; 0 is replaced by 8'h01

Legality constraints:
- `NUM_PIPES*PIPE_SPACING >= SCREEN_W+PIPE_W`
- `NUM_PIPES*PIPE_SPACING + PIPE_W < 2048`
- `HOLE_MIN+255+GAP_H <= SCREEN_H`

Ports:
- `clk` in 1: pixel clock. Single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame. Issued during vertical blanking.
- `run` in 1: 1 = scroll and score on ticks; 0 = positions frozen.
- `restart` in 1: synchronous one-cycle request to return to the initial field.
- `pix_x`, `pix_y` in 10 each: current pixel coordinates.
- `video_active` in 1: pixel is visible.
- `bird_y` in 9: bird top row, stable across a frame.
- `pipe_pix` out 1: pixel is pipe body (2-cycle latency).
- `gap_pix` out 1: pixel is inside a pipe's column and hole.
- `bird_pix` out 1: pixel is bird.
- `collide` out 1: sticky collision flag.
- `score` out 8: pipes passed, saturating at 255.
- `score_pulse` out 1: one-cycle pulse on each score increment.

## Operation
Per-channel state:
- `x_i`: 11-bit unsigned left edge.
- `hole_i`: 9-bit hole top row.

Initial field (reset or restart):
- `x_i = SCREEN_W + i*PIPE_SPACING`
- `hole_i = (SCREEN_H-GAP_H)/2` (190 at defaults)
- `score = 0`, `collide = 0`
- The LFSR is reset by `rst_n` only; `restart` does not touch it.

LFSR:
- 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
- Advances exactly once per `frame_tick`, regardless of `run`.

Tick with `run=1`, evaluated per channel:
- If `x_i < SPEED`: respawn.
  - `x_i <= x_i + NUM_PIPES*PIPE_SPACING - SPEED`
  - `hole_i <= HOLE_MIN + lfsr` (pre-advance value)
  - If several channels respawn in the same tick, all take the same LFSR value.
- Else: `x_i <= x_i - SPEED`.

Scoring:
- A channel scores when `x_i+PIPE_W >= BIRD_X` before the tick and `< BIRD_X` after it.
- Each scoring channel adds 1; the total saturates at 255.
- `score_pulse` fires when at least one channel scores and `score < 255`.
- Tick with `run=0`: positions, holes and score are unchanged.

Render pipeline:
- Stage 1 registers `pix_x`, `pix_y`, `video_active` and the per-channel compares:
  - in_x: `x_i < SCREEN_W` and `x_i <= pix_x < x_i+PIPE_W`
  - in_gap: `hole_i <= pix_y < hole_i+GAP_H`
- Stage 2 registers the outputs, all gated by the delayed `video_active`:
  - `pipe_pix` = OR of (in_x & ~in_gap)
  - `gap_pix` = OR of (in_x & in_gap)
  - `bird_pix` = `BIRD_X <= x < BIRD_X+BIRD_SIZE` and `bird_y <= y < bird_y+BIRD_SIZE`
- A pipe whose left edge wraps (x_i < SPEED → respawn) disappears abruptly at column 0. Partial left-edge clipping is not supported.

Collision:
- Set when stage-2 `pipe_pix & bird_pix` is 1.
- Set on a tick with `run=1` when `bird_y+BIRD_SIZE > SCREEN_H` (9-bit sum extended to 10 bits).
- Sticky until `restart` or reset.

## Timing
- Reset values: all outputs 0; `x_i`/`hole_i` hold the initial field; lfsr = seed.
- Pixel outputs lag `pix_x`/`pix_y` by exactly 2 clocks. Upstream delays hsync/vsync by 2 to match.
- State updates one clock after `frame_tick`.
- `score_pulse` is high in the cycle following the tick.
- `restart` together with `frame_tick`: restart wins. Field and score are reinitialised; no scoring or collision; the LFSR still advances.
- `restart` together with a collision set condition: `collide` ends at 0.
- `rst_n` asserted mid-frame: all state clears immediately (asynchronous). The pipeline restarts with zeros.
- Positions change only on ticks. The renderer sees one consistent field per frame.

## Test plan
- **Reset and scroll:** reset, `run=1`, one tick → x = 638/878/1118; no pixel output at (70,50).
- **Scoring:** 290 ticks → x0=60, score=0; tick 291 → x0=58, score=1, one `score_pulse`.
- **Respawn:** 320 ticks → x0=0; tick 321 → x0=718 and hole0 = 40+LFSR value; the LFSR value is checked against the model.
- **Render:** at x0=60, pixel (70,50) → `pipe_pix`=1; (70,200) → `gap_pix`=1; (70,290) → `pipe_pix`=1. Each appears 2 clocks after the pixel; all 0 when `video_active`=0.
- **Collision:** at x0=80 with `bird_y`=45, pixel (100,45) → `collide`=1 and it stays set over later frames. `restart` → collide=0, score=0, x0=640.
- **Freeze and floor:** `run=0` ticks leave x unchanged while the LFSR advances. `bird_y`=475 with `run=1` on a tick → `collide`=1.
